// File: rtl/bus_master_port.sv
// Bus master port: turns one parallel read/write command into a serial frame.
// Sequence: arbitrate, shift the address out MSB-first, move the data, then pulse a response.
module bus_master_port #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_error,
   output logic                  bus_req,
   input  logic                  bus_grant,
   output logic                  m_valid,
   output logic                  m_mode,
   output logic                  m_dout,
   input  logic                  m_din,
   input  logic                  s_ready,
   input  logic                  s_valid
);

   localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_ADDR,
      S_WWAIT,
      S_WDATA,
      S_RWAIT,
      S_RDATA,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic                  fail;
   logic                  write_q;
   logic                  err_q;
   logic [ADDR_WIDTH-1:0] addr_sh;
   logic [DATA_WIDTH-1:0] data_sh;
   logic [DATA_WIDTH-1:0] rdata_sh;
   logic [CNT_W-1:0]      bit_cnt;
   logic [TMO_W-1:0]      tmo_cnt;
   logic                  accept;
   logic                  entering;
   logic                  shifting;
   logic                  waiting;

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Grant loss is checked first in every bus-owning state; a simultaneous
   // timeout yields the same error outcome, so only one DONE results.
   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned (no latches).
      state_d = state_q;
      fail    = 1'b0;
      case (state_q)
         S_IDLE:  if (cmd_valid) state_d = S_REQ;
         S_REQ:   if (bus_grant) state_d = S_ADDR;
         S_ADDR: begin
            if (!bus_grant) begin
               state_d = S_DONE;
               fail    = 1'b1;
            end else if (bit_cnt == ADDR_LAST) begin
               state_d = write_q ? S_WWAIT : S_RWAIT;
            end
         end
         S_WWAIT: begin
            if (!bus_grant) begin
               state_d = S_DONE;
               fail    = 1'b1;
            end else if (s_ready) begin
               state_d = S_WDATA;
            end else if (tmo_cnt == TMO_LAST) begin
               state_d = S_DONE;
               fail    = 1'b1;
            end
         end
         S_WDATA: begin
            if (!bus_grant) begin
               state_d = S_DONE;
               fail    = 1'b1;
            end else if (bit_cnt == DATA_LAST) begin
               state_d = S_DONE;
            end
         end
         S_RWAIT: begin
            if (!bus_grant) begin
               state_d = S_DONE;
               fail    = 1'b1;
            end else if (s_valid) begin
               state_d = S_RDATA;
            end else if (tmo_cnt == TMO_LAST) begin
               state_d = S_DONE;
               fail    = 1'b1;
            end
         end
         S_RDATA: begin
            if (!bus_grant) begin
               state_d = S_DONE;
               fail    = 1'b1;
            end else if (bit_cnt == DATA_LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign accept   = (state_q == S_IDLE) && cmd_valid;
   assign entering = (state_d != state_q);
   assign shifting = (state_q == S_ADDR) || (state_q == S_WDATA) || (state_q == S_RDATA);
   assign waiting  = (state_q == S_WWAIT) || (state_q == S_RWAIT);

   // Counters restart on every state change, which clears the timeout on entry to a wait state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         write_q  <= 1'b0;
         err_q    <= 1'b0;
         addr_sh  <= '0;
         data_sh  <= '0;
         rdata_sh <= '0;
         bit_cnt  <= '0;
         tmo_cnt  <= '0;
      end else begin
         if (accept) begin
            write_q  <= cmd_write;
            addr_sh  <= cmd_addr;
            data_sh  <= cmd_wdata;
            rdata_sh <= '0;
            err_q    <= 1'b0;
         end

         case (state_q)
            S_ADDR:  addr_sh  <= {addr_sh[ADDR_WIDTH-2:0], 1'b0};
            S_WDATA: data_sh  <= {data_sh[DATA_WIDTH-2:0], 1'b0};
            S_RDATA: rdata_sh <= {rdata_sh[DATA_WIDTH-2:0], m_din};
            default: ;
         endcase

         if (entering)      bit_cnt <= '0;
         else if (shifting) bit_cnt <= bit_cnt + CNT_W'(1);

         if (entering)     tmo_cnt <= '0;
         else if (waiting) tmo_cnt <= tmo_cnt + TMO_W'(1);

         if (entering && (state_d == S_DONE)) err_q <= fail;
      end
   end

   always_comb begin
      cmd_ready = (state_q == S_IDLE);
      bus_req   = (state_q != S_IDLE) && (state_q != S_DONE);
      m_valid   = bus_req && (state_q != S_REQ);
      m_mode    = m_valid && write_q;
      m_dout    = 1'b0;
      if (state_q == S_ADDR)  m_dout = addr_sh[ADDR_WIDTH-1];
      if (state_q == S_WDATA) m_dout = data_sh[DATA_WIDTH-1];
      rsp_valid = (state_q == S_DONE);
      rsp_error = rsp_valid && err_q;
      rsp_rdata = (rsp_valid && !err_q && !write_q) ? rdata_sh : '0;
   end

endmodule

// File: tb/tb_bus_master_port.sv
// Self-checking bench for bus_master_port: scoreboarded responses plus
// cycle-by-cycle frame checks derived from the command and bus stimulus.
module tb_bus_master_port;

   localparam int AW = 12;
   localparam int DW = 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_error;
   logic [DW-1:0] rsp_rdata;
   logic          bus_req, bus_grant;
   logic          m_valid, m_mode, m_dout, m_din;
   logic          s_ready, s_valid;

   typedef struct {
      int            lat;
      logic          err;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   bus_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_error (rsp_error),
      .bus_req   (bus_req),
      .bus_grant (bus_grant),
      .m_valid   (m_valid),
      .m_mode    (m_mode),
      .m_dout    (m_dout),
      .m_din     (m_din),
      .s_ready   (s_ready),
      .s_valid   (s_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives one command and its bus-side stimulus. gd = grant delay cycles,
   // sd = slave handshake delay (-1 = never), drop = data bit during which grant is lost (-1 = none).
   task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int gd, input int sd, input logic [DW-1:0] sdata,
                          input int drop, input logic poke);
      int            a0, w0, d0, wait_len, drop_cyc, lat;
      logic          err;
      logic [DW-1:0] rd;
      bit            done;
      exp_t          e, x;
      a0       = gd + 2;
      w0       = a0 + AW;
      wait_len = (sd >= 0) ? sd + 1 : TO;
      d0       = w0 + wait_len;
      drop_cyc = (drop >= 0) ? d0 + drop : -1;
      if (drop_cyc > 0) begin
         lat = drop_cyc + 1;
         err = 1'b1;
      end else begin
         lat = d0 + ((sd >= 0) ? DW : 0);
         err = (sd < 0);
      end
      rd = (!wr && !err) ? sdata : '0;

      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      check("cmd_ready_idle", cmd_ready, 1'b1);
      e = '{lat, err, rd};
      sb.push_back(e);

      done = 1'b0;
      for (int k = 1; !done; k++) begin
         @(posedge clk);
         #1;
         if (poke && k < lat - 2) begin
            cmd_valid = 1'b1;
            cmd_write = !wr;
            cmd_addr  = ~addr;
            cmd_wdata = ~wdata;
         end else begin
            cmd_valid = 1'b0;
         end
         bus_grant = (k > gd) && !(drop_cyc > 0 && k >= drop_cyc);
         s_ready   = wr && (sd >= 0) && (k >= w0 + sd);
         s_valid   = !wr && (sd >= 0) && (k >= w0 + sd);
         m_din     = (!wr && k >= d0 && k < d0 + DW) ? sdata[DW-1-(k-d0)] : 1'b0;
         @(negedge clk);
         if (rsp_valid) begin
            done = 1'b1;
            if (sb.size() == 0) begin
               check("sb_underflow", sb.size(), 1);
            end else begin
               x = sb.pop_front();
               check("rsp_cycle", k, x.lat);
               check("rsp_err_rdata", {rsp_error, rsp_rdata}, {x.err, x.rdata});
               check("done_bus_idle", {bus_req, m_valid}, 2'b00);
            end
         end else if (k >= lat) begin
            done = 1'b1;
            check("rsp_missing", rsp_valid, 1'b1);
         end else if (k <= gd + 1) begin
            check("req_phase", {bus_req, m_valid, cmd_ready}, 3'b100);
         end else if (k < w0) begin
            check("addr_bit", {bus_req, m_valid, m_mode, m_dout},
                  {1'b1, 1'b1, wr, addr[AW-1-(k-a0)]});
         end else if (k < d0) begin
            check("wait_phase", {bus_req, m_valid, m_mode, m_dout}, {1'b1, 1'b1, wr, 1'b0});
         end else if (wr) begin
            check("wdata_bit", {bus_req, m_valid, m_mode, m_dout},
                  {1'b1, 1'b1, 1'b1, wdata[DW-1-(k-d0)]});
         end else begin
            check("rdata_frame", {bus_req, m_valid, m_mode}, 3'b110);
         end
      end

      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      bus_grant = 1'b0;
      s_ready   = 1'b0;
      s_valid   = 1'b0;
      m_din     = 1'b0;
      @(negedge clk);
      check("post_done_idle", {bus_req, m_valid, rsp_valid, cmd_ready}, 4'b0001);
      if (poke) begin
         repeat (3) begin
            @(negedge clk);
            check("busy_cmd_ignored", {bus_req, rsp_valid, cmd_ready}, 3'b001);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      bus_grant = 1'b0;
      m_din     = 1'b0;
      s_ready   = 1'b0;
      s_valid   = 1'b0;
      #12;
      check("reset_ctrl", {cmd_ready, rsp_valid, rsp_error, bus_req, m_valid, m_mode, m_dout},
            7'b1000000);
      check("reset_rdata", rsp_rdata, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      run_cmd(1'b1, 12'hA5C, 8'hAA, 0,  0, 8'h00, -1, 1'b0);  // basic write, 23 cycles
      run_cmd(1'b0, 12'h062, 8'h00, 0,  0, 8'h62, -1, 1'b0);  // basic read
      run_cmd(1'b1, 12'h3C1, 8'h5A, 5,  0, 8'h00, -1, 1'b0);  // late grant, 28 cycles
      run_cmd(1'b1, 12'h7E8, 8'hFF, 0, -1, 8'h00, -1, 1'b0);  // s_ready never: timeout
      run_cmd(1'b0, 12'h155, 8'h00, 0,  0, 8'hB7,  3, 1'b0);  // grant lost on 4th data bit
      run_cmd(1'b0, 12'hF0F, 8'h00, 0,  3, 8'hC3, -1, 1'b0);  // s_valid after 3 wait cycles

      // Reset in the middle of the address phase.
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 12'hABC;
      cmd_wdata = 8'h11;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      bus_grant = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("pre_reset_addr", {bus_req, m_valid}, 2'b11);
      #2;
      reset = 1'b0;
      #1;
      check("mid_reset_ctrl", {cmd_ready, rsp_valid, rsp_error, bus_req, m_valid, m_mode, m_dout},
            7'b1000000);
      check("mid_reset_rdata", rsp_rdata, 0);
      @(posedge clk);
      @(negedge clk);
      reset     = 1'b1;
      bus_grant = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("after_reset_idle", {cmd_ready, rsp_valid, bus_req}, 3'b100);
      end

      run_cmd(1'b1, 12'h9A6, 8'h3D, 2, 1, 8'h00, -1, 1'b1);   // busy cmd_valid ignored
      run_cmd(1'b0, 12'h00F, 8'h00, 0, 0, 8'h81, -1, 1'b1);

      check("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
